mux_rr_arbiter: RTL and testbench
=================================

Name: mux_rr_arbiter

Overview:
- Shares one output channel between N_REQ requesters using a valid/ready handshake.
- Round-robin arbitration drives the select of an N_REQ:1 data mux.
- The mux output feeds a one-entry registered output buffer.
- Sits in front of any single shared consumer that is fed through mux instances.

Parameters:
N_REQ, 4, number of requesters (2..16)
W, 8, data width per requester
IDX_W, $clog2(N_REQ), grant index width (derived, not overridden)

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  N_REQ  requester i has data
req_data  input  N_REQ*W  packed data, requester i at bits [i*W +: W]
req_ready  output  N_REQ  one-hot or zero; beat from requester i accepted this cycle
out_valid  output  1  output buffer holds a beat
out_data  output  W  buffered beat
out_src  output  IDX_W  index of the requester that supplied out_data
out_ready  input  1  consumer accepts the beat

Behaviour:
- Reset (async assert, sync-style release on clk):
  - out_valid=0, out_data=0, out_src=0
  - rr pointer ptr=0, FSM=EMPTY
- FSM states: EMPTY (buffer empty), FULL (buffer holds a beat).
- can_load = (state==EMPTY) | (out_ready & out_valid).
- Arbitration (combinational):
  - Candidate = first i with req_valid[i] set, scanning ptr, ptr+1, ... with wrap mod N_REQ.
  - req_ready[cand]=1 only if can_load and some req_valid is set; all other bits 0.
  - req_ready never asserted for an invalid requester.
- Load on accept:
  - out_data<=req_data[cand], out_src<=cand, out_valid<=1.
  - ptr<=(cand==N_REQ-1)?0:cand+1.
- Transitions:
  - EMPTY + accept -> FULL.
  - FULL + out_ready + accept -> FULL. Pop and load in the same cycle gives full throughput, 1 beat/cycle.
  - FULL + out_ready + no request -> EMPTY, out_valid<=0. out_data holds its last value.
  - FULL + !out_ready -> FULL. out_data, out_src and ptr are held; req_ready all 0.
- Latency: a beat accepted at cycle t appears on out_valid/out_data at t+1.
- ptr advances only on an accept. Idle cycles do not rotate it.
- Fairness: with all requesters continuously valid, grants are 0,1,..,N_REQ-1,0,... Worst-case wait is N_REQ-1 accepts.
- No combinational path from out_ready to out_valid/out_data. req_ready depends combinationally on out_ready and req_valid.
- req_valid may drop without a handshake. The arbiter does not need data stability from unselected requesters.
- Reset asserted mid-transfer: the buffered beat is discarded and out_valid drops immediately (asynchronous).

Optional Feature:
- Macro: MUX_RR_ARBITER_LOCK_EN.
- With the macro defined:
  - Adds input req_last [N_REQ] and output out_last.
  - After accepting a beat with req_last[i]=0, the grant is locked to i. ptr is not advanced and no other requester is served.
  - The lock holds until a beat from i with req_last[i]=1 is accepted; ptr then becomes i+1.
  - out_last mirrors the captured req_last. Reset clears the lock.
- Without the macro: no req_last/out_last ports; every beat is arbitrated independently.

Decomposition:
- Package mux_arb_pkg holds:
  - typedef enum logic {ARB_EMPTY, ARB_FULL} arb_state_t
  - function rr_next(idx, n) for the wrap increment
- Sub-module rr_pick (combinational):
  - inputs: req vector, ptr
  - outputs: one-hot grant, grant index, any_req
  - implementation: double-width vector rotate, then priority encode
  - reusable by other arbiters in the codebase

Test Plan:
- Reset: rst_n=0 mid-run with out_valid=1 -> out_valid=0, req_ready=0000 in the same cycle. After release the first grant goes to req 0.
- All four valid, data 8'hA0+i, out_ready=1 -> out_src sequence 0,1,2,3,0 on consecutive cycles, out_data A0,A1,A2,A3,A0, no bubbles.
- Sparse: only req 2 then req 1 valid with ptr=3 -> req 2 granted, ptr=3. Next, req 1 granted via wrap 3->0->1.
- Backpressure: out_ready=0 for 5 cycles with FULL -> req_ready=0000, out_data/out_src stable. On out_ready=1 the next requester in round-robin order loads the same cycle.
- Drain: single beat from req 3 then no requests, out_ready=1 -> out_valid high one cycle then 0, state EMPTY, ptr=0.
- LOCK_EN: req 1 sends 3 beats (last on 3rd) while req 0 and req 2 are valid -> out_src 1,1,1, then 2, then 0; out_last=0,0,1.

Source files
------------

// File: rtl/mux_arb_pkg.sv
// rtl/mux_arb_pkg.sv - shared types and helpers for the round-robin mux arbiter
//
// Purpose : FSM state encoding and the wrap-increment helper used by the
//           arbiter top to advance its round-robin pointer.
// Contents: arb_state_t  - ARB_EMPTY (output buffer empty), ARB_FULL (holds a beat)
//           rr_next()    - (idx + 1) mod n, written as a compare so no divider is built
package mux_arb_pkg;

  typedef enum logic {
    ARB_EMPTY = 1'b0,
    ARB_FULL  = 1'b1
  } arb_state_t;

  function automatic int rr_next(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin pick over a request vector
//
// Purpose : Find the first set request at or after ptr_i, wrapping mod N.
// Ports   : req_i   [N]     request vector
//           ptr_i   [IDX_W] highest-priority position this cycle
//           grant_o [N]     one-hot grant (zero when no request)
//           idx_o   [IDX_W] index of the granted request (0 when none)
//           any_o           at least one request is set
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     grant_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  localparam logic [IDX_W:0] N_EXT = (IDX_W + 1)'(N);

  logic [2*N-1:0]   dbl;
  logic [N-1:0]     rot;
  logic [IDX_W-1:0] off;
  logic [IDX_W:0]   sum;

  always_comb begin
    // Rotating a doubled copy puts position ptr_i at bit 0, so a plain
    // lowest-bit-first priority encoder yields the distance from ptr_i.
    dbl = {req_i, req_i} >> ptr_i;
    rot = dbl[N-1:0];
    off = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) off = IDX_W'(i);
    end
    // Map the distance back to an absolute index; one subtract suffices
    // because both operands are below N.
    sum = {1'b0, ptr_i} + {1'b0, off};
    if (sum >= N_EXT) sum = sum - N_EXT;
    idx_o   = sum[IDX_W-1:0];
    any_o   = |req_i;
    grant_o = any_o ? (N'(1) << idx_o) : '0;
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// rtl/mux_rr_arbiter.sv - round-robin N:1 mux with one-entry registered output buffer
//
// Purpose : Share one valid/ready output channel between N_REQ requesters.
//           A round-robin pick selects the mux input; the chosen beat is
//           captured in a one-entry buffer. Pop and load may happen in the
//           same cycle, giving one beat per cycle of throughput.
// Ports   : clk, rst_n            clock, asynchronous active-low reset
//           req_valid [N_REQ]     requester i has a beat
//           req_data  [N_REQ*W]   requester i at bits [i*W +: W]
//           req_ready [N_REQ]     one-hot or zero; beat from i accepted this cycle
//           out_valid/out_data    buffered beat
//           out_src   [IDX_W]     requester that supplied out_data
//           out_ready             consumer takes the buffered beat
// Option  : MUX_RR_ARBITER_LOCK_EN adds req_last [N_REQ] / out_last. A beat
//           accepted without last locks the grant to its requester until a
//           beat with last is accepted from it.
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter  int N_REQ = 4,
  parameter  int W     = 8,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ*W-1:0] req_data,
  output logic [N_REQ-1:0]   req_ready,
  output logic               out_valid,
  output logic [W-1:0]       out_data,
  output logic [IDX_W-1:0]   out_src,
  input  logic               out_ready
`ifdef MUX_RR_ARBITER_LOCK_EN
  ,
  input  logic [N_REQ-1:0]   req_last,
  output logic               out_last
`endif
);

  arb_state_t       state_q;
  logic             out_valid_q;
  logic [W-1:0]     out_data_q;
  logic [IDX_W-1:0] out_src_q;
  logic [IDX_W-1:0] ptr_q, ptr_d;

  logic [N_REQ-1:0] req_eff;
  logic [N_REQ-1:0] cand_oh;
  logic [IDX_W-1:0] cand_idx;
  logic             any_req;
  logic             can_load;
  logic             accept;
  logic [W-1:0]     cand_data;

`ifdef MUX_RR_ARBITER_LOCK_EN
  logic             lock_q;
  logic [IDX_W-1:0] lock_idx_q;
  logic             out_last_q;
  logic             cand_last;

  // While locked only the owning requester is visible to the picker.
  assign req_eff   = lock_q ? (req_valid & (N_REQ'(1) << lock_idx_q)) : req_valid;
  assign cand_last = req_last[cand_idx];
  assign out_last  = out_last_q;
`else
  assign req_eff   = req_valid;
`endif

  rr_pick #(
    .N     (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req_i   (req_eff),
    .ptr_i   (ptr_q),
    .grant_o (cand_oh),
    .idx_o   (cand_idx),
    .any_o   (any_req)
  );

  assign can_load  = (state_q == ARB_EMPTY) | (out_ready & out_valid_q);
  // rst_n gates the handshake so nothing is accepted while reset is held.
  assign accept    = rst_n & can_load & any_req;
  assign req_ready = accept ? cand_oh : '0;
  assign cand_data = req_data[cand_idx*W +: W];

  always_comb begin
    ptr_d = ptr_q;
    if (accept) begin
`ifdef MUX_RR_ARBITER_LOCK_EN
      // Inside a locked burst the pointer stays put; it moves past the
      // owner only once the closing beat is taken.
      if (cand_last) ptr_d = IDX_W'(rr_next(int'(cand_idx), N_REQ));
`else
      ptr_d = IDX_W'(rr_next(int'(cand_idx), N_REQ));
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ARB_EMPTY;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      ptr_q       <= '0;
`ifdef MUX_RR_ARBITER_LOCK_EN
      lock_q      <= 1'b0;
      lock_idx_q  <= '0;
      out_last_q  <= 1'b0;
`endif
    end else begin
      ptr_q <= ptr_d;
      if (accept) begin
        out_data_q <= cand_data;
        out_src_q  <= cand_idx;
`ifdef MUX_RR_ARBITER_LOCK_EN
        out_last_q <= cand_last;
        lock_q     <= ~cand_last;
        lock_idx_q <= cand_idx;
`endif
      end
      case (state_q)
        ARB_EMPTY: begin
          if (accept) begin
            out_valid_q <= 1'b1;
            state_q     <= ARB_FULL;
          end
        end
        ARB_FULL: begin
          // Without out_ready everything holds. With it, either a new beat
          // replaces the popped one or the buffer drains to empty.
          if (out_ready && !accept) begin
            out_valid_q <= 1'b0;
            state_q     <= ARB_EMPTY;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          state_q     <= ARB_EMPTY;
        end
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb/tb_mux_rr_arbiter.sv - self-checking bench for mux_rr_arbiter
module tb_mux_rr_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N*W-1:0] req_data = '0;
  logic [N-1:0]   req_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [1:0]     out_src;
  logic           out_ready = 1'b0;
`ifdef MUX_RR_ARBITER_LOCK_EN
  logic [N-1:0]   req_last = '0;
  logic           out_last;
`endif

  mux_rr_arbiter #(.N_REQ(N), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready)
`ifdef MUX_RR_ARBITER_LOCK_EN
    ,
    .req_last  (req_last),
    .out_last  (out_last)
`endif
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Behavioural model: buffer contents, pointer and lock owner.
  bit     m_valid;
  int     m_data, m_src, m_ptr, m_lock_idx;
  bit     m_lock, m_last;
  bit     use_fixed;
  logic [N-1:0] obs_rr;

  function automatic void model_reset();
    m_valid = 0; m_data = 0; m_src = 0; m_ptr = 0;
    m_lock = 0; m_lock_idx = 0; m_last = 0;
  endfunction

  function automatic int model_cand(input logic [N-1:0] v);
    int i;
    if (m_lock) return v[m_lock_idx] ? m_lock_idx : -1;
    for (int k = 0; k < N; k++) begin
      i = (m_ptr + k) % N;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a falling edge: drive, check against the model, clock, update.
  task automatic step(input logic [N-1:0] v, input bit rdy, input logic [N-1:0] lst);
    int c;
    bit can_load, acc;
    logic [N-1:0] exp_rr;
    req_valid = v;
    out_ready = rdy;
    req_data  = use_fixed ? {8'hA3, 8'hA2, 8'hA1, 8'hA0} : N*W'($urandom);
`ifdef MUX_RR_ARBITER_LOCK_EN
    req_last = lst;
`endif
    #1;
    can_load = !m_valid || rdy;
    c = model_cand(v);
    acc = can_load && (c >= 0);
    exp_rr = acc ? (N'(1) << c) : '0;
    obs_rr = req_ready;
    chk("req_ready", 32'(req_ready), 32'(exp_rr));
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("out_data", 32'(out_data), 32'(m_data));
    chk("out_src", 32'(out_src), 32'(m_src));
`ifdef MUX_RR_ARBITER_LOCK_EN
    chk("out_last", 32'(out_last), 32'(m_last));
`endif
    @(posedge clk);
    if (acc) begin
      m_valid = 1;
      m_data  = int'(req_data[c*W +: W]);
      m_src   = c;
      m_last  = lst[c];
`ifdef MUX_RR_ARBITER_LOCK_EN
      m_lock = !lst[c];
      m_lock_idx = c;
      if (lst[c]) m_ptr = (c + 1) % N;
`else
      m_ptr = (c + 1) % N;
`endif
    end else if (m_valid && rdy) begin
      m_valid = 0;
    end
    @(negedge clk);
  endtask

  localparam logic [N-1:0] ALL_LAST = '1;

  initial begin
    model_reset();
    use_fixed = 0;
    req_valid = 4'b1111;
    @(negedge clk);
    #1;
    chk("reset_out_valid", 32'(out_valid), 0);
    chk("reset_out_data", 32'(out_data), 0);
    chk("reset_out_src", 32'(out_src), 0);
    chk("reset_req_ready", 32'(req_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Round robin with every requester valid, no bubbles.
    use_fixed = 1;
    for (int k = 0; k < 5; k++) begin
      step(4'b1111, 1'b1, ALL_LAST);
      chk("rr_valid", 32'(out_valid), 1);
      chk("rr_src", 32'(out_src), 32'(k % 4));
      chk("rr_data", 32'(out_data), 32'(8'hA0 + k % 4));
    end
    use_fixed = 0;

    // Reset with a beat buffered.
    rst_n = 1'b0;
    req_valid = 4'b1111;
    #1;
    chk("midreset_out_valid", 32'(out_valid), 0);
    chk("midreset_req_ready", 32'(req_ready), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(4'b1111, 1'b1, ALL_LAST);
    chk("post_reset_rr", 32'(obs_rr), 32'(4'b0001));

    // Sparse requests, wrap 3 -> 0 -> 1.
    step(4'b0100, 1'b1, ALL_LAST);
    chk("sparse_src_a", 32'(out_src), 2);
    step(4'b0100, 1'b1, ALL_LAST);
    chk("sparse_src_b", 32'(out_src), 2);
    step(4'b0010, 1'b1, ALL_LAST);
    chk("sparse_src_wrap", 32'(out_src), 1);

    // Backpressure holds the buffer and blocks all requesters.
    for (int k = 0; k < 5; k++) begin
      step(4'b1111, 1'b0, ALL_LAST);
      chk("bp_req_ready", 32'(obs_rr), 0);
      chk("bp_src", 32'(out_src), 1);
    end
    step(4'b1111, 1'b1, ALL_LAST);
    chk("bp_release_rr", 32'(obs_rr), 32'(4'b0100));
    chk("bp_release_src", 32'(out_src), 2);

    // Drain after a single beat from requester 3.
    step(4'b1000, 1'b1, ALL_LAST);
    chk("drain_rr", 32'(obs_rr), 32'(4'b1000));
    chk("drain_valid_hi", 32'(out_valid), 1);
    step(4'b0000, 1'b1, ALL_LAST);
    chk("drain_valid_lo", 32'(out_valid), 0);
    step(4'b1111, 1'b1, ALL_LAST);
    chk("drain_ptr0", 32'(obs_rr), 32'(4'b0001));

`ifdef MUX_RR_ARBITER_LOCK_EN
    // Pointer is 1 here: requester 1 holds the grant for a 3-beat burst.
    step(4'b0111, 1'b1, 4'b0101);
    chk("lock_src0", 32'(out_src), 1);
    chk("lock_last0", 32'(out_last), 0);
    step(4'b0111, 1'b1, 4'b0101);
    chk("lock_src1", 32'(out_src), 1);
    chk("lock_last1", 32'(out_last), 0);
    step(4'b0111, 1'b1, 4'b0111);
    chk("lock_src2", 32'(out_src), 1);
    chk("lock_last2", 32'(out_last), 1);
    step(4'b0111, 1'b1, 4'b0111);
    chk("lock_src3", 32'(out_src), 2);
    step(4'b0111, 1'b1, 4'b0111);
    chk("lock_src4", 32'(out_src), 0);
`endif

    // Random traffic, valid may drop freely, out_ready mostly high.
    for (int k = 0; k < 3000; k++) begin
      step(N'($urandom), $urandom_range(0, 3) != 0, N'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
